// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues data-memory requests for loads and stores,
// extends load results and forwards ALU results to writeback through one output register.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_reg_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic [3:0]  mem_write_mask,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid
);

  typedef enum logic [0:0] {IDLE, LOAD_WAIT} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_reg_write_q, out_reg_write_d;
  logic [31:0] ld_addr_q, ld_addr_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        out_free;
  logic        accept;

  function automatic logic [3:0] store_mask(input logic [1:0] width);
    case (width)
      2'd0:    store_mask = 4'b0001;
      2'd1:    store_mask = 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // funct3[2] selects zero extension; it has no effect on full-word loads.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    extend = f3[2] ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    extend = f3[2] ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign out_free = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d          = state_q;
    out_valid_d      = out_valid_q;
    out_rd_d         = out_rd_q;
    out_data_d       = out_data_q;
    out_reg_write_d  = out_reg_write_q;
    ld_addr_d        = ld_addr_q;
    ld_funct3_d      = ld_funct3_q;
    ld_rd_d          = ld_rd_q;
    in_ready         = 1'b0;
    mem_address      = 32'd0;
    mem_write_data   = 32'd0;
    mem_write_enable = 1'b0;
    mem_write_mask   = 4'd0;
    mem_read_enable  = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        in_ready = rst_n && out_free;
        if (accept) begin
          if (in_is_store) begin
            mem_address      = in_addr;
            mem_write_data   = in_store_data;
            mem_write_enable = 1'b1;
            mem_write_mask   = store_mask(in_funct3[1:0]);
            out_valid_d      = 1'b1;
            out_rd_d         = in_rd;
            out_data_d       = in_addr;
            out_reg_write_d  = 1'b0;
          end else if (in_is_load) begin
            mem_address     = in_addr;
            mem_read_enable = 1'b1;
            ld_addr_d       = in_addr;
            ld_funct3_d     = in_funct3;
            ld_rd_d         = in_rd;
            state_d         = LOAD_WAIT;
          end else begin
            out_valid_d     = 1'b1;
            out_rd_d        = in_rd;
            out_data_d      = in_addr;
            out_reg_write_d = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        // Request stays asserted on an unchanged address until the result can be taken.
        mem_address     = ld_addr_q;
        mem_read_enable = 1'b1;
        if (mem_read_valid && out_free) begin
          out_valid_d     = 1'b1;
          out_rd_d        = ld_rd_q;
          out_data_d      = extend(mem_read_data, ld_funct3_q);
          out_reg_write_d = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      out_valid_q     <= 1'b0;
      out_rd_q        <= 5'd0;
      out_data_q      <= 32'd0;
      out_reg_write_q <= 1'b0;
      ld_addr_q       <= 32'd0;
      ld_funct3_q     <= 3'd0;
      ld_rd_q         <= 5'd0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      out_rd_q        <= out_rd_d;
      out_data_q      <= out_data_d;
      out_reg_write_q <= out_reg_write_d;
      ld_addr_q       <= ld_addr_d;
      ld_funct3_q     <= ld_funct3_d;
      ld_rd_q         <= ld_rd_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rd        = out_rd_q;
  assign out_data      = out_data_q;
  assign out_reg_write = out_reg_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-addressed memory model
// that drops read_valid for one cycle when the read address changes.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_reg_write;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable, mem_read_valid;
  logic [3:0]  mem_write_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .out_reg_write(out_reg_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_write_mask(mem_write_mask),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid)
  );

  // Memory model: 1 KiB, address wraps; cleared while reset is held.
  logic [7:0]  mem [0:1023];
  logic [31:0] rd_addr_q;
  logic        rv_q = 1'b0;
  logic [31:0] rdata_q = 32'd0;
  logic [9:0]  a;

  assign mem_read_valid = rv_q;
  assign mem_read_data  = rdata_q;

  always @(posedge clk) begin
    a = mem_address[9:0];
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'd0;
      rv_q <= 1'b0;
    end else begin
      if (mem_write_enable)
        for (int i = 0; i < 4; i++)
          if (mem_write_mask[i]) mem[a + 10'(i)] <= mem_write_data[8*i +: 8];
      if (mem_read_enable) begin
        if (rv_q && mem_address != rd_addr_q) begin
          rv_q <= 1'b0;
        end else begin
          rv_q    <= 1'b1;
          rdata_q <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
        end
        rd_addr_q <= mem_address;
      end else begin
        rv_q <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_store_data = sd; in_rd = rd;
    #1;
    $display("drive ld=%0b st=%0b f3=%0d addr=0x%08h sd=0x%08h rd=%0d", ld, st, f3, addr, sd, rd);
  endtask

  task automatic clr();
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1; in_funct3 = 3'd2;
    in_addr = 32'h40; in_store_data = 32'h11; in_rd = 5'd1;

    // Reset state, with a store presented that must not reach memory
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_reg_write", out_reg_write, 0);
    chk("rst_mem_we", mem_write_enable, 0);
    chk("rst_mem_re", mem_read_enable, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_mask", mem_write_mask, 0);
    clr();
    rst_n = 1'b1;

    // ALU pass-through
    @(negedge clk); drive(0, 0, 3'd0, 32'h12345678, 32'd0, 5'd3);
    chk("alu_in_ready", in_ready, 1);
    chk("alu_mem_idle", {mem_read_enable, mem_write_enable}, 0);
    @(negedge clk);
    chk("alu_out_valid", out_valid, 1);
    chk("alu_out_data", out_data, 32'h12345678);
    chk("alu_out_rd", out_rd, 3);
    chk("alu_reg_write", out_reg_write, 1);

    // SW 0xDEADBEEF @0x100
    drive(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd7);
    chk("sw_we", mem_write_enable, 1);
    chk("sw_mask", mem_write_mask, 4'b1111);
    chk("sw_wdata", mem_write_data, 32'hDEADBEEF);
    chk("sw_addr", mem_address, 32'h100);
    chk("sw_re", mem_read_enable, 0);
    @(negedge clk);
    chk("sw_out_valid", out_valid, 1);
    chk("sw_reg_write", out_reg_write, 0);

    // LW @0x100 immediately after the store
    drive(1, 0, 3'd2, 32'h100, 32'd0, 5'd5);
    chk("lw_re_accept", mem_read_enable, 1);
    chk("lw_addr_accept", mem_address, 32'h100);
    chk("lw_we_accept", mem_write_enable, 0);
    @(negedge clk); clr();
    chk("lw_t1_out_valid", out_valid, 0);
    chk("lw_t1_in_ready", in_ready, 0);
    chk("lw_t1_re", mem_read_enable, 1);
    chk("lw_t1_addr", mem_address, 32'h100);
    @(negedge clk);
    chk("lw_t2_out_valid", out_valid, 1);
    chk("lw_t2_data", out_data, 32'hDEADBEEF);
    chk("lw_t2_rd", out_rd, 5);
    chk("lw_t2_reg_write", out_reg_write, 1);
    chk("lw_t2_re_idle", mem_read_enable, 0);

    // SB 0x80 @0x103, then LB and LBU (same address back to back)
    drive(0, 1, 3'd0, 32'h103, 32'h12345680, 5'd1);
    chk("sb_mask", mem_write_mask, 4'b0001);
    chk("sb_wdata", mem_write_data, 32'h12345680);
    @(negedge clk); drive(1, 0, 3'd0, 32'h103, 32'd0, 5'd8);
    @(negedge clk); clr();
    @(negedge clk);
    chk("lb_out_valid", out_valid, 1);
    chk("lb_data", out_data, 32'hFFFFFF80);
    drive(1, 0, 3'd4, 32'h103, 32'd0, 5'd9);
    @(negedge clk); clr();
    chk("lbu_t1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("lbu_t2_out_valid", out_valid, 1);
    chk("lbu_data", out_data, 32'h00000080);

    // Unaligned SH 0xA55A @0x1FF, then LH
    drive(0, 1, 3'd1, 32'h1FF, 32'h0000A55A, 5'd0);
    chk("sh_mask", mem_write_mask, 4'b0011);
    chk("sh_addr", mem_address, 32'h1FF);
    @(negedge clk); drive(1, 0, 3'd1, 32'h1FF, 32'd0, 5'd10);
    chk("lh_addr", mem_address, 32'h1FF);
    @(negedge clk); clr();
    @(negedge clk);
    chk("lh_out_valid", out_valid, 1);
    chk("lh_data", out_data, 32'hFFFFA55A);

    // Back-to-back loads to different addresses
    drive(0, 0, 3'd0, 32'hCAFE0000, 32'd0, 5'd11);
    @(negedge clk);
    chk("alu2_data", out_data, 32'hCAFE0000);
    drive(1, 0, 3'd2, 32'h100, 32'd0, 5'd12);
    @(negedge clk); clr();
    @(negedge clk);
    chk("b2b1_t2_out_valid", out_valid, 1);
    chk("b2b1_data", out_data, 32'h80ADBEEF);
    drive(1, 0, 3'd5, 32'h1FF, 32'd0, 5'd13);
    @(negedge clk); clr();
    chk("b2b2_t1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("b2b2_t2_out_valid", out_valid, 0);
    @(negedge clk);
    chk("b2b2_t3_out_valid", out_valid, 1);
    chk("b2b2_data", out_data, 32'h0000A55A);
    chk("b2b2_rd", out_rd, 13);

    // Back-pressure across a load completion
    drive(1, 0, 3'd2, 32'h100, 32'd0, 5'd14);
    @(negedge clk); clr(); out_ready = 1'b0;
    @(negedge clk);
    chk("bp_t2_out_valid", out_valid, 0);
    @(negedge clk);
    chk("bp_t3_out_valid", out_valid, 1);
    chk("bp_t3_data", out_data, 32'h80ADBEEF);
    chk("bp_t3_in_ready", in_ready, 0);
    @(negedge clk);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 32'h80ADBEEF);
    drive(0, 0, 3'd0, 32'h55AA55AA, 32'd0, 5'd15);
    chk("bp_hold_in_ready", in_ready, 0);
    @(negedge clk);
    chk("bp_hold2_data", out_data, 32'h80ADBEEF);
    chk("bp_hold2_rd", out_rd, 14);
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk); clr();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 32'h55AA55AA);
    chk("bp_next_rd", out_rd, 15);

    // Reset while in LOAD_WAIT
    drive(1, 0, 3'd2, 32'h100, 32'd0, 5'd16);
    @(negedge clk); clr();
    chk("rml_re_before", mem_read_enable, 1);
    rst_n = 1'b0; #1;
    chk("rml_re", mem_read_enable, 0);
    chk("rml_addr", mem_address, 0);
    chk("rml_out_valid", out_valid, 0);
    chk("rml_out_data", out_data, 0);
    chk("rml_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rml_post_out_valid", out_valid, 0);
    chk("rml_post_in_ready", in_ready, 1);
    chk("rml_post_re", mem_read_enable, 0);
    drive(0, 0, 3'd0, 32'h0BADF00D, 32'd0, 5'd17);
    @(negedge clk); clr();
    chk("rml_new_valid", out_valid, 1);
    chk("rml_new_data", out_data, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
